fp_regfile_mp: RTL and testbench
================================

Name: fp_regfile_mp

Overview:
- Parametrised successor to the single-precision FPU register file.
- Holds NREGS floating-point registers of FLEN bits, with NRD combinational read ports and one synchronous write port; NRD defaults to 3 so fused multiply-add can read rs1, rs2 and rs3.
- Adds a pending-write scoreboard: issue marks a destination busy, writeback clears it.
- Sits between FPU decode/issue and the FPU execute/writeback stage.

Parameters:
- FLEN, 32, register data width in bits (32 or 64).
- NREGS, 32, number of FP registers; power of two, at least 2.
- NRD, 3, number of read ports, 1 to 4.
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- reg_write  in  1  writeback enable.
- write_reg  in  AW  writeback address.
- write_data  in  FLEN  writeback data.
- read_reg  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- read_data  out  NRD*FLEN  packed read data; port i uses bits [i*FLEN +: FLEN].
- read_busy  out  NRD  per-port flag: the addressed register has a pending write.
- issue_valid  in  1  an op with an FP destination is being issued.
- issue_rd  in  AW  destination register of the issuing op.
- busy_vec  out  NREGS  scoreboard state, bit r = register r pending.

Behaviour:
- Reset: every register is 0 and busy_vec is 0, one cycle after rst is sampled high. Reset has priority over reg_write and issue_valid in the same cycle. Reset mid-operation discards all pending ops with no residual busy bits.
- f0 is an ordinary writable register; no hardwired zero.
- Write: on a rising edge with reg_write=1, regs[write_reg] <= write_data.
- Read: read_data[i] = regs[read_reg[i]], combinational with 0-cycle latency. Any number of ports may address the same register.
- Scoreboard set/clear:
  - On a rising edge, issue_valid=1 sets busy[issue_rd].
  - On a rising edge, reg_write=1 clears busy[write_reg].
- Same register issued and written back in the same cycle: the set wins and the bit stays 1. This is the new op superseding the old.
- Different registers issued and written back in the same cycle: both updates apply.
- Writeback to a non-busy register is legal (loads, moves). The data is written and the busy bit stays 0.
- Issue to an already-busy register is legal; the bit stays 1 (no counting).
- read_busy[i] = busy[read_reg[i]], with the bypass adjustment below when FP_RF_BYPASS_EN is defined.
- No X propagation: all addresses are in range by construction because NREGS is a power of two.

Optional Feature:
- Macro: FP_RF_BYPASS_EN.
- Defined:
  - Write-through bypass is enabled.
  - When reg_write=1 and write_reg == read_reg[i], read_data[i] = write_data in the same cycle.
  - read_busy[i] = 0 for that port unless issue_valid=1 with issue_rd == read_reg[i] in the same cycle.
- Undefined:
  - Reads return the pre-write value during the write cycle; the new value is visible the cycle after.
  - read_busy reflects the registered busy bit only.

Decomposition:
- Shared package fpu_pkg:
  - FLEN_DEFAULT = 32 and NREGS_DEFAULT = 32.
  - Canonical quiet NaN constant 32'h7FC00000, for later NaN-boxing use.
  - Typedef fp_reg_t, an FLEN-bit logic vector.
- One natural sub-module, fp_scoreboard: NREGS busy bits with the set/clear priority rules and per-port lookups.
- The data array and read muxes stay in fp_regfile_mp.

Test Plan:
- Reset: drive arbitrary writes, then rst=1 for 1 cycle -> all read_data read 0 on every port; busy_vec=0.
- Triple read:
  - Write f1=32'h3F800000, f2=32'h40000000, f3=32'h40400000 on consecutive cycles.
  - Then read_reg={3,2,1} -> read_data={40400000,40000000,3F800000}.
  - Also set all ports to f2 -> all three read 40000000.
- Scoreboard:
  - issue_valid with issue_rd=5 -> busy_vec[5]=1 next cycle; read_busy=1 on any port addressing 5.
  - reg_write to 5 -> bit clears the following cycle.
- Collision: busy[7]=1, then issue_rd=7 and write_reg=7 in the same cycle -> busy[7] remains 1 and regs[7] holds write_data.
- Bypass:
  - Write f9=32'hC0A00000 while read_reg[0]=9.
  - With FP_RF_BYPASS_EN -> C0A00000 in the same cycle.
  - Without -> old value that cycle, C0A00000 next cycle.
- Reset mid-operation: busy on f4 and f6, assert rst -> busy_vec=0; a subsequent writeback to f4 leaves busy_vec=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default register file geometry, canonical quiet NaN
// and the FP register data type.
package fpu_pkg;

  localparam int FLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Kept for NaN-boxing single-precision values in a 64-bit register file.
  localparam logic [31:0] CANONICAL_QNAN = 32'h7FC00000;

  typedef logic [FLEN_DEFAULT-1:0] fp_reg_t;

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-write scoreboard for the FP register file: issue sets a busy bit,
// writeback clears it, with per-read-port lookups (bypass-aware under FP_RF_BYPASS_EN).
module fp_scoreboard
  import fpu_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              reg_write,
  input  logic [AW-1:0]     write_reg,
  input  logic [NRD*AW-1:0] read_reg,
  output logic [NRD-1:0]    read_busy,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  // Set is applied after clear so a same-register issue supersedes the writeback.
  always_comb begin
    busy_next = busy;
    if (reg_write)
      busy_next[write_reg] = 1'b0;
    if (issue_valid)
      busy_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_next;
  end

  always_comb begin
    read_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      read_busy[i] = busy[read_reg[i*AW +: AW]];
`ifdef FP_RF_BYPASS_EN
      // A register written back this cycle is only pending if re-issued this cycle.
      if (reg_write && (write_reg == read_reg[i*AW +: AW]))
        read_busy[i] = issue_valid && (issue_rd == read_reg[i*AW +: AW]);
`endif
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file with pending-write scoreboard.
// Optional write-through bypass enabled by defining FP_RF_BYPASS_EN.
module fp_regfile_mp
  import fpu_pkg::*;
#(
  parameter int FLEN  = FLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 3,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reg_write,
  input  logic [AW-1:0]       write_reg,
  input  logic [FLEN-1:0]     write_data,
  input  logic [NRD*AW-1:0]   read_reg,
  output logic [NRD*FLEN-1:0] read_data,
  output logic [NRD-1:0]      read_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic [NREGS-1:0]    busy_vec
);

  logic [FLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else if (reg_write) begin
      regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NRD; i++) begin
      read_data[i*FLEN +: FLEN] = regs[read_reg[i*AW +: AW]];
`ifdef FP_RF_BYPASS_EN
      if (reg_write && (write_reg == read_reg[i*AW +: AW]))
        read_data[i*FLEN +: FLEN] = write_data;
`endif
    end
  end

  fp_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .read_reg    (read_reg),
    .read_busy   (read_busy),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Self-checking bench for fp_regfile_mp: directed plan followed by random traffic,
// compared against an array-based reference model (honours FP_RF_BYPASS_EN).
module tb_fp_regfile_mp;

  localparam int FLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                reg_write;
  logic [AW-1:0]       write_reg;
  logic [FLEN-1:0]     write_data;
  logic [NRD*AW-1:0]   read_reg;
  logic [NRD*FLEN-1:0] read_data;
  logic [NRD-1:0]      read_busy;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [NREGS-1:0]    busy_vec;

  logic [FLEN-1:0] model_regs [NREGS];
  bit              model_busy [NREGS];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fp_regfile_mp #(
    .FLEN  (FLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg    (read_reg),
    .read_data   (read_data),
    .read_busy   (read_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_vec    (busy_vec)
  );

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected combinational view: register contents, plus write-through when bypass is built in.
  task automatic check_reads();
    logic [AW-1:0]   addr;
    logic [FLEN-1:0] exp_data;
    logic            exp_busy;
    for (int p = 0; p < NRD; p++) begin
      addr     = read_reg[p*AW +: AW];
      exp_data = model_regs[addr];
      exp_busy = model_busy[addr];
`ifdef FP_RF_BYPASS_EN
      if (reg_write && write_reg == addr) begin
        exp_data = write_data;
        exp_busy = issue_valid && issue_rd == addr;
      end
`endif
      check_output($sformatf("read_data[%0d] f%0d", p, addr), 64'(read_data[p*FLEN +: FLEN]), 64'(exp_data));
      check_output($sformatf("read_busy[%0d] f%0d", p, addr), 64'(read_busy[p]), 64'(exp_busy));
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit we, input int wa, input logic [FLEN-1:0] wd,
                                input bit iv, input int ird, input int ra0, input int ra1,
                                input int ra2, input bit chk = 1'b1);
    logic [NREGS-1:0] exp_vec;
    rst         = r;
    reg_write   = we;
    write_reg   = AW'(wa);
    write_data  = wd;
    issue_valid = iv;
    issue_rd    = AW'(ird);
    read_reg    = {AW'(ra2), AW'(ra1), AW'(ra0)};
    #2;
    if (chk) check_reads();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NREGS; i++) begin
        model_regs[i] = '0;
        model_busy[i] = 1'b0;
      end
    end else begin
      if (we) begin
        model_regs[wa] = wd;
        model_busy[wa] = 1'b0;
      end
      if (iv) model_busy[ird] = 1'b1;
    end
    #1;
    for (int i = 0; i < NREGS; i++) exp_vec[i] = model_busy[i];
    check_output("busy_vec", 64'(busy_vec), 64'(exp_vec));
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      model_regs[i] = '0;
      model_busy[i] = 1'b0;
    end
    // Reset wins over a simultaneous write and issue.
    apply_stimulus(1, 1, 3, 32'hDEADBEEF, 1, 2, 0, 1, 2, 0);
    apply_stimulus(0, 1, 3, 32'h12345678, 1, 10, 0, 1, 2);
    apply_stimulus(0, 1, 0, 32'hCAFEF00D, 1, 11, 3, 0, 10);
    apply_stimulus(1, 1, 4, 32'h55555555, 1, 12, 3, 0, 11);
    apply_stimulus(0, 0, 0, '0, 0, 0, 3, 0, 4);
    apply_stimulus(0, 0, 0, '0, 0, 0, 10, 11, 12);
    // Triple read.
    apply_stimulus(0, 1, 1, 32'h3F800000, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 2, 32'h40000000, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 3, 32'h40400000, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, '0, 0, 0, 1, 2, 3);
    apply_stimulus(0, 0, 0, '0, 0, 0, 2, 2, 2);
    // Scoreboard set then clear.
    apply_stimulus(0, 0, 0, '0, 1, 5, 5, 0, 0);
    apply_stimulus(0, 0, 0, '0, 0, 0, 5, 5, 1);
    apply_stimulus(0, 1, 5, 32'h41200000, 0, 0, 5, 0, 5);
    apply_stimulus(0, 0, 0, '0, 0, 0, 5, 5, 5);
    // Same-cycle issue and writeback on f7: set wins, data written.
    apply_stimulus(0, 0, 0, '0, 1, 7, 7, 0, 0);
    apply_stimulus(0, 1, 7, 32'hBF800000, 1, 7, 7, 7, 0);
    apply_stimulus(0, 1, 8, 32'h11111111, 1, 13, 7, 8, 13);
    apply_stimulus(0, 0, 0, '0, 0, 0, 7, 8, 13);
    // Write-through behaviour on f9.
    apply_stimulus(0, 1, 9, 32'hC0A00000, 0, 0, 9, 1, 2);
    apply_stimulus(0, 0, 0, '0, 0, 0, 9, 9, 9);
    // Reset mid-operation.
    apply_stimulus(0, 0, 0, '0, 1, 4, 4, 6, 0);
    apply_stimulus(0, 0, 0, '0, 1, 6, 4, 6, 0);
    apply_stimulus(1, 0, 0, '0, 0, 0, 4, 6, 9);
    apply_stimulus(0, 1, 4, 32'h40800000, 0, 0, 4, 6, 9);
    apply_stimulus(0, 0, 0, '0, 0, 0, 4, 6, 1);
    // Random traffic over a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? NREGS - 1 : 7;
      apply_stimulus($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, lim), $urandom, $urandom_range(0, 1) == 1,
                     $urandom_range(0, lim), $urandom_range(0, lim),
                     $urandom_range(0, lim), $urandom_range(0, lim));
    end
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
